uart_txfifo_wr_arb: RTL and testbench
=====================================

# uart_txfifo_wr_arb

- Single-clock write-port arbiter and flush sequencer for the UART transmit FIFO.
- Shares the FIFO write port (`wr`, `d`) between two byte requesters (CPU register path, loopback/test path) using round-robin arbitration with an optional message lock.
- Honours the FIFO `full` flag and sequences FIFO flushes through the FIFO's `srst` input.
- Sits in the FIFO write-clock domain, between the requesters and the async FIFO.

## Interface

Parameters:
- `FLUSH_WAIT`, default 8: quiet cycles after `fifo_srst` before writes resume. Range 1..255.
- `LOCK_TIMEOUT`, default 64: idle cycles a locked owner may hold the port before the lock is forcibly dropped. Range 1..1023.

Ports:
- `clk`  in  1  write-side clock
- `rst`  in  1  reset; synchronous, active-high
- `req0_valid` / `req1_valid`  in  1  requester has a byte
- `req0_data` / `req1_data`  in  8  byte to write
- `req0_lock` / `req1_lock`  in  1  qualifies the byte: 1 = more bytes of this message follow
- `req0_ready` / `req1_ready`  out  1  byte accepted this cycle when valid&ready
- `flush`  in  1  request FIFO flush; level-sampled
- `fifo_full`  in  1  FIFO full flag
- `fifo_wr`  out  1  FIFO write strobe
- `fifo_d`  out  8  FIFO write data
- `fifo_srst`  out  1  FIFO synchronous reset pulse
- `flush_busy`  out  1  flush sequence in progress
- `grant`  out  2  one-hot current owner; 00 when nobody is eligible
- `lock_timeout`  out  1  one-cycle pulse when a lock is forcibly dropped

## Operation

- **States.**
  - RUN: normal arbitration.
  - FLUSH: `fifo_srst`=1 for exactly one cycle.
  - WAIT: counts `FLUSH_WAIT` cycles.
- **Transitions.**
  - RUN→FLUSH when `flush`=1.
  - FLUSH→WAIT unconditionally.
  - WAIT→RUN when the count reaches `FLUSH_WAIT`.
  - `flush`=1 in WAIT goes back to FLUSH and restarts the sequence.
- **Registered state:** `last` (last served requester), `lock_active`, `owner`, wait counter, idle counter.
- **Grant** is combinational from registered state plus the `valid` inputs, and is evaluated in RUN only.
  - If `lock_active`: `grant` = `owner`, regardless of the owner's `valid`.
  - Else, both valid: grant the requester ≠ `last`.
  - Else, one valid: grant that requester.
  - Else: 00.
- **Ready and write path:**
  - `reqN_ready` = RUN & `grant[N]` & ~`fifo_full`.
  - `fifo_wr` = OR of (`reqN_valid` & `reqN_ready`).
  - `fifo_d` = granted requester's data when a grant is active, else 00.
- **On a transfer by N:**
  - `last`←N, `owner`←N.
  - `lock_active`←`reqN_lock`. The final byte of a message carries lock=0 and releases the port.
- **Lock timeout.**
  - While `lock_active`, the idle counter increments on cycles with no owner transfer and clears on a transfer.
  - At `LOCK_TIMEOUT`: `lock_active`←0 and `lock_timeout` pulses for 1 cycle.
  - `fifo_full` cycles count as idle.
- **Flush.**
  - Entering FLUSH clears `lock_active` and the idle counter, and sets `last`←1.
  - All `ready`=0 in FLUSH and WAIT.
  - `flush_busy`=1 in FLUSH and WAIT.
  - `flush` and a transfer in the same RUN cycle: the transfer completes, then the flush follows. The flushed FIFO discards that byte.
- **Counter widths:** wait counter 8 bits, idle counter 10 bits. Both saturate and never wrap.

## Timing

- **Reset values:**
  - State RUN; `last`=1, so req0 wins the first contention.
  - `lock_active`=0, `owner`=0, counters 0.
  - `fifo_wr`=0, `fifo_srst`=0, `flush_busy`=0, `lock_timeout`=0.
  - `grant`=00 when there is no valid request.
- Accept-to-`fifo_wr` latency is 0 cycles (same cycle). Maximum throughput is 1 byte/cycle.
- `fifo_full` is a registered FIFO output, so there is no combinational loop through `ready`.
- **Flush timeline:**
  - `flush` sampled at edge t.
  - `fifo_srst`=1 during cycle t+1.
  - `ready` is next possible in cycle t+2+`FLUSH_WAIT`.
- `rst` mid-flush or mid-lock returns to reset values on the next edge. `fifo_srst` drops in the same edge.

## Test plan

- **Alternation.** Both requesters valid continuously, no lock, `fifo_full`=0 → `fifo_d` sequence req0, req1, req0, … starting with req0 after reset, one byte per cycle.
- **Locked message.** req1 sends 3 bytes with lock=1,1,0 while req0 is valid throughout → three consecutive req1 bytes, then req0 granted on the next cycle.
- **Backpressure.** `fifo_full`=1 for 5 cycles with both valid → `fifo_wr`=0 and both `ready`=0 for those cycles; the pending grant is retained and that requester is served first after `full` drops.
- **Flush.** Pulse `flush` in RUN with `FLUSH_WAIT`=8 → `fifo_srst` high exactly 1 cycle, `flush_busy` high 9 cycles, first write no earlier than the 10th cycle after sampling; a second `flush` during WAIT restarts the 9-cycle window.
- **Lock timeout.** req0 sends lock=1 then goes idle, `LOCK_TIMEOUT`=4, req1 valid → no `fifo_wr` for 4 cycles, then a 1-cycle `lock_timeout` pulse, and req1 served the following cycle.
- **Reset mid-operation.** Assert `rst` during a lock and again during WAIT → the next cycle shows all reset values and req0 priority.

Source files
------------

// File: rtl/uart_txfifo_wr_arb_if.sv
// Write-port bundle between the two byte requesters, the arbiter and the TX FIFO.
// The arbiter takes the slave view; the requester/FIFO side takes the master view.
interface uart_txfifo_wr_arb_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_lock;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_lock;
  logic       req1_ready;
  logic       fifo_full;
  logic       fifo_wr;
  logic [7:0] fifo_d;
  logic       fifo_srst;

  modport master (
    output req0_valid, req0_data, req0_lock,
    output req1_valid, req1_data, req1_lock,
    output fifo_full,
    input  req0_ready, req1_ready,
    input  fifo_wr, fifo_d, fifo_srst
  );

  modport slave (
    input  req0_valid, req0_data, req0_lock,
    input  req1_valid, req1_data, req1_lock,
    input  fifo_full,
    output req0_ready, req1_ready,
    output fifo_wr, fifo_d, fifo_srst
  );
endinterface

// File: rtl/uart_txfifo_wr_arb.sv
// Round-robin write-port arbiter with message lock, lock timeout and flush sequencing
// for the UART transmit FIFO. Everything lives in the FIFO write-clock domain.
module uart_txfifo_wr_arb #(
  parameter int unsigned FLUSH_WAIT   = 8,
  parameter int unsigned LOCK_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_txfifo_wr_arb_if.slave        bus,
  input  logic                       flush,
  output logic                       flush_busy,
  output logic [1:0]                 grant,
  output logic                       lock_timeout
);

  localparam logic [7:0] WaitLast  = 8'(FLUSH_WAIT - 1);
  localparam logic [9:0] IdleLimit = 10'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {StRun, StFlush, StWait} state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;    // last served requester
  logic       lock_q, lock_d;
  logic       owner_q, owner_d;
  logic [7:0] wait_q, wait_d;
  logic [9:0] idle_q, idle_d;

  logic       ready0, ready1;
  logic       xfer0, xfer1, wr;
  logic [7:0] wdata;

  // Grant decode and write datapath, combinational from registered state and valids.
  always_comb begin
    grant = 2'b00;
    if (state_q == StRun) begin
      if (lock_q) begin
        grant = owner_q ? 2'b10 : 2'b01;
      end else if (bus.req0_valid && bus.req1_valid) begin
        grant = last_q ? 2'b01 : 2'b10;
      end else if (bus.req0_valid) begin
        grant = 2'b01;
      end else if (bus.req1_valid) begin
        grant = 2'b10;
      end
    end
    ready0 = grant[0] & ~bus.fifo_full;
    ready1 = grant[1] & ~bus.fifo_full;
    xfer0  = bus.req0_valid & ready0;
    xfer1  = bus.req1_valid & ready1;
    wr     = xfer0 | xfer1;
    case (grant)
      2'b01:   wdata = bus.req0_data;
      2'b10:   wdata = bus.req1_data;
      default: wdata = 8'h00;
    endcase
    // While locked only the owner can transfer, so any write counts as owner activity.
    lock_timeout = lock_q & (idle_q == IdleLimit) & ~wr;
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.fifo_wr    = wr;
  assign bus.fifo_d     = wdata;
  assign bus.fifo_srst  = (state_q == StFlush);
  assign flush_busy     = (state_q != StRun);

  // Next-state logic for the flush sequencer, arbitration history, lock and counters.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    lock_d  = lock_q;
    owner_d = owner_q;
    wait_d  = wait_q;
    idle_d  = idle_q;
    unique case (state_q)
      StRun: begin
        if (wr) begin
          last_d  = xfer1;
          owner_d = xfer1;
          lock_d  = xfer1 ? bus.req1_lock : bus.req0_lock;
          idle_d  = 10'd0;
        end else if (lock_timeout) begin
          lock_d = 1'b0;
          idle_d = 10'd0;
        end else if (lock_q && idle_q != 10'h3ff) begin
          idle_d = idle_q + 10'd1;
        end
        // A same-cycle transfer still completes; the flush then discards it.
        if (flush) begin
          state_d = StFlush;
          lock_d  = 1'b0;
          idle_d  = 10'd0;
          last_d  = 1'b1;
        end
      end
      StFlush: begin
        state_d = StWait;
        wait_d  = 8'd0;
      end
      StWait: begin
        if (flush) begin
          state_d = StFlush;
        end else if (wait_q == WaitLast) begin
          state_d = StRun;
        end else if (wait_q != 8'hff) begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // State register with synchronous reset; last=1 gives req0 the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      last_q  <= 1'b1;
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      wait_q  <= 8'd0;
      idle_q  <= 10'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      wait_q  <= wait_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: tb/tb_uart_txfifo_wr_arb.sv
// Directed bench for uart_txfifo_wr_arb with FLUSH_WAIT=8, LOCK_TIMEOUT=4.
// Each check compares a packed snapshot {grant, wr, rdy0, rdy1, srst, busy, lock_to, d}.
module tb_uart_txfifo_wr_arb;
  logic       clk;
  logic       rst;
  logic       flush;
  logic       flush_busy;
  logic [1:0] grant;
  logic       lock_timeout;
  int         vecs = 0;
  int         miss = 0;

  uart_txfifo_wr_arb_if bus ();

  uart_txfifo_wr_arb #(
    .FLUSH_WAIT  (8),
    .LOCK_TIMEOUT(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .flush       (flush),
    .flush_busy  (flush_busy),
    .grant       (grant),
    .lock_timeout(lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ex(input logic [1:0] g, input logic w, input logic r0,
                                     input logic r1, input logic s, input logic b,
                                     input logic lt, input logic [7:0] d);
    return {g, w, r0, r1, s, b, lt, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample on the falling edge, away from the active edge.
  task automatic chk(input string tag, input logic [15:0] exp);
    logic [15:0] obs;
    @(negedge clk);
    obs = {grant, bus.fifo_wr, bus.req0_ready, bus.req1_ready, bus.fifo_srst, flush_busy,
           lock_timeout, bus.fifo_d};
    vecs++;
    assert (obs === exp)
    else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req0_lock  = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 8'h00;
    bus.req1_lock  = 1'b0;
    bus.fifo_full  = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_idle", ex(2'b00, 0, 0, 0, 0, 0, 0, 8'h00));

    // Alternation starting with req0.
    for (int i = 0; i < 6; i++) begin
      step();
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req0_data  = 8'h10 + 8'(i);
      bus.req1_data  = 8'h80 + 8'(i);
      if (i % 2 == 0) chk($sformatf("alt_%0d", i), ex(2'b01, 1, 1, 0, 0, 0, 0, 8'h10 + 8'(i)));
      else            chk($sformatf("alt_%0d", i), ex(2'b10, 1, 0, 1, 0, 0, 0, 8'h80 + 8'(i)));
    end

    // Locked three-byte message from req1 while req0 stays valid.
    step(); bus.req0_data = 8'h21; bus.req1_data = 8'h31; bus.req1_lock = 1'b1;
    chk("lock_pre_req0", ex(2'b01, 1, 1, 0, 0, 0, 0, 8'h21));
    step(); bus.req1_data = 8'h32;
    chk("lock_byte1", ex(2'b10, 1, 0, 1, 0, 0, 0, 8'h32));
    step(); bus.req1_data = 8'h33;
    chk("lock_byte2", ex(2'b10, 1, 0, 1, 0, 0, 0, 8'h33));
    step(); bus.req1_data = 8'h34; bus.req1_lock = 1'b0;
    chk("lock_byte3", ex(2'b10, 1, 0, 1, 0, 0, 0, 8'h34));
    step(); bus.req0_data = 8'h25;
    chk("lock_release", ex(2'b01, 1, 1, 0, 0, 0, 0, 8'h25));

    // Backpressure: req1 holds the pending grant through 5 full cycles.
    for (int i = 0; i < 5; i++) begin
      step(); bus.fifo_full = 1'b1; bus.req1_data = 8'h40;
      chk($sformatf("full_%0d", i), ex(2'b10, 0, 0, 0, 0, 0, 0, 8'h40));
    end
    step(); bus.fifo_full = 1'b0;
    chk("full_drop_req1", ex(2'b10, 1, 0, 1, 0, 0, 0, 8'h40));
    step(); bus.req0_data = 8'h26;
    chk("full_after_req0", ex(2'b01, 1, 1, 0, 0, 0, 0, 8'h26));

    // Flush with a same-cycle transfer, then the 9-cycle busy window.
    step(); flush = 1'b1; bus.req0_data = 8'h27; bus.req1_data = 8'h41;
    chk("flush_req_xfer", ex(2'b10, 1, 0, 1, 0, 0, 0, 8'h41));
    step(); flush = 1'b0;
    chk("flush_srst", ex(2'b00, 0, 0, 0, 1, 1, 0, 8'h00));
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("flush_wait_%0d", i), ex(2'b00, 0, 0, 0, 0, 1, 0, 8'h00));
    end
    step();
    chk("flush_resume_req0", ex(2'b01, 1, 1, 0, 0, 0, 0, 8'h27));

    // Second flush restarted from inside WAIT.
    step(); flush = 1'b1;
    chk("flush2_req", ex(2'b10, 1, 0, 1, 0, 0, 0, 8'h41));
    step(); flush = 1'b0;
    chk("flush2_srst", ex(2'b00, 0, 0, 0, 1, 1, 0, 8'h00));
    step();
    step();
    step(); flush = 1'b1;
    chk("flush2_wait_reflush", ex(2'b00, 0, 0, 0, 0, 1, 0, 8'h00));
    step(); flush = 1'b0;
    chk("flush2_restart_srst", ex(2'b00, 0, 0, 0, 1, 1, 0, 8'h00));
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("flush2_wait_%0d", i), ex(2'b00, 0, 0, 0, 0, 1, 0, 8'h00));
    end
    step();
    chk("flush2_resume", ex(2'b01, 1, 1, 0, 0, 0, 0, 8'h27));

    // Lock timeout: req0 locks then goes idle; req1 waits.
    step(); bus.req1_valid = 1'b0; bus.req0_lock = 1'b1; bus.req0_data = 8'h5a;
    chk("to_lock_req0", ex(2'b01, 1, 1, 0, 0, 0, 0, 8'h5a));
    step(); bus.req0_valid = 1'b0; bus.req0_lock = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h6b;
    chk("to_idle_0", ex(2'b01, 0, 1, 0, 0, 0, 0, 8'h5a));
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("to_idle_%0d", i), ex(2'b01, 0, 1, 0, 0, 0, 0, 8'h5a));
    end
    step();
    chk("to_pulse", ex(2'b01, 0, 1, 0, 0, 0, 1, 8'h5a));
    step(); bus.req1_lock = 1'b1;
    chk("to_req1_served", ex(2'b10, 1, 0, 1, 0, 0, 0, 8'h6b));

    // Reset while req1 holds a lock.
    step(); rst = 1'b1; bus.req0_valid = 1'b1; bus.req1_lock = 1'b0;
    step(); rst = 1'b0;
    chk("rst_lock_req0", ex(2'b01, 1, 1, 0, 0, 0, 0, 8'h5a));

    // Reset during WAIT.
    step(); flush = 1'b1;
    chk("rstw_flush_req", ex(2'b10, 1, 0, 1, 0, 0, 0, 8'h6b));
    step(); flush = 1'b0;
    chk("rstw_srst", ex(2'b00, 0, 0, 0, 1, 1, 0, 8'h00));
    step();
    chk("rstw_wait", ex(2'b00, 0, 0, 0, 0, 1, 0, 8'h00));
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    chk("rstw_after", ex(2'b01, 1, 1, 0, 0, 0, 0, 8'h5a));

    // Reset during FLUSH: srst drops at the reset edge.
    step(); flush = 1'b1;
    chk("rstf_flush_req", ex(2'b10, 1, 0, 1, 0, 0, 0, 8'h6b));
    step(); flush = 1'b0; rst = 1'b1;
    chk("rstf_srst", ex(2'b00, 0, 0, 0, 1, 1, 0, 8'h00));
    step(); rst = 1'b0;
    chk("rstf_after", ex(2'b01, 1, 1, 0, 0, 0, 0, 8'h5a));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
